spart_tx_engine: RTL and testbench
==================================

Name: spart_tx_engine

Overview:
- Parametrised SPART transmit engine: the next-generation TX path, with the control FSM, the holding buffer, the shift register and the serial output in one block.
- Adds configurable data width, runtime parity (none/even/odd), 1 or 2 stop bits, a double-buffered holding register for back-to-back frames with no idle gap, and an overrun flag.
- Sits between the processor IO bus decode and the TXD pin. Bit timing comes from the shared baud-rate generator enable (brg_en).

Parameters:
- DATA_BITS, 8, payload bits per frame. Legal range 5..9.
- SAMPLE_RATE, 16, brg_en pulses per serial bit. Must be >= 2.
- CNT_W, $clog2(SAMPLE_RATE), width of the sample counter. Derived; must not be overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ioaddr  in  2  IO register address; 2'b00 is the TX data register
- iorw  in  1  1 = read, 0 = write
- iocs  in  1  chip select
- data_in  in  DATA_BITS  write data, meaningful when a write is accepted
- brg_en  in  1  one-cycle baud tick from the baud-rate generator
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- two_stop  in  1  1 = two stop bits
- tbr  out  1  transmit buffer ready (holding register empty)
- busy  out  1  frame in progress on txd
- overrun  out  1  one-cycle pulse when a write is dropped
- txd  out  1  serial output, idle high

Behaviour:
- Reset (async, rst_n low): txd=1, tbr=1, busy=0, overrun=0. FSM goes to IDLE; counters, holding register and shifter clear. Reset mid-frame forces txd high at once and discards the frame and any buffered byte.
- Write strobe: wr = iocs & ~iorw & (ioaddr==2'b00).
- Acceptance: wr is accepted if the holding register is empty, or if it is being transferred to the shifter in the same cycle.
  - Accepted: data_in is captured and tbr=0 from the next cycle.
  - Otherwise: the write is dropped and overrun=1 for exactly the next cycle. The holding-register contents are unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: txd=1, busy=0. On the first brg_en with the holding register full:
  - transfer the byte to the shifter;
  - latch parity_mode and two_stop;
  - tbr=1, busy=1, txd=0 next cycle;
  - go to START.
- Configuration inputs are sampled only at frame load. Changes mid-frame take effect on the next frame.
- Bit timing: each bit holds txd for exactly SAMPLE_RATE brg_en pulses. The sample counter increments on brg_en. The bit ends on the pulse that brings the count to SAMPLE_RATE-1; the counter then wraps to 0 and the next bit drives txd on the following cycle. brg_en is ignored outside bit counting, except for the IDLE load.
- START (txd=0) -> DATA.
- DATA: txd = shifter LSB. Shift right at each bit end. After DATA_BITS bits, go to PARITY if parity is enabled, else to STOP. The bit counter is 4 bits and resets at START.
- PARITY:
  - even: txd = ^data;
  - odd: txd = ~^data;
  - parity is computed over the latched payload.
- STOP: txd=1 for 1 or 2 bit times. At the end of the last stop bit:
  - holding register full -> load it immediately (same cycle, no idle bit time) and go to START;
  - otherwise -> IDLE, busy=0.
- Frame length in brg_en pulses = (1 + DATA_BITS + P + S) * SAMPLE_RATE, where P is 0/1 and S is 1/2.
- Simultaneous wr and load in the same cycle: the old byte goes to the shifter and the new byte goes to the holding register. There is no overrun.
- brg_en held high continuously is legal; the frame then takes the minimum time.

Test Plan:
- Reset with frame active: assert rst_n=0 mid-DATA -> txd=1, tbr=1, busy=0 asynchronously; after release, no residual frame.
- 8N1, SAMPLE_RATE=16, write 8'hA5, brg_en every 4 clk -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 clk; frame 160 brg_en; busy falls after the stop bit.
- Parity: 8'h07 with parity_mode=01 -> parity bit 1; parity_mode=10 -> parity bit 0; two_stop=1 -> 2*SAMPLE_RATE high before IDLE.
- Back-to-back: write 8'h55, then 8'h0F while the first frame is in DATA -> tbr=0 until the second load; the second start bit begins on the tick right after the first stop bit, with no idle bit.
- Overrun: with the shifter busy and the holding register full, write 8'h33 -> overrun pulses 1 cycle; the transmitted second byte equals the previously buffered value.
- DATA_BITS=5 and DATA_BITS=9 builds: write all-ones -> correct bit count and parity, upper data_in bits not transmitted for DATA_BITS=5.

Source files
------------

// File: rtl/spart_tx_engine.sv
// SPART transmit engine: double-buffered holding register, framing FSM and
// serial shifter driving TXD, paced by the shared baud-rate generator tick.
module spart_tx_engine #(
   parameter int DATA_BITS   = 8,
   parameter int SAMPLE_RATE = 16,
   parameter int CNT_W       = $clog2(SAMPLE_RATE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           ioaddr,
   input  logic                 iorw,
   input  logic                 iocs,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 brg_en,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic                 tbr,
   output logic                 busy,
   output logic                 overrun,
   output logic                 txd
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state;
   logic [CNT_W-1:0]     sample_cnt;
   logic [3:0]           bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] hold_reg;
   logic                 hold_full;
   logic [DATA_BITS-1:0] shifter;
   logic [DATA_BITS-1:0] payload;
   logic [1:0]           par_q;
   logic                 two_q;

   logic wr, bit_end, last_stop, load, accept, par_en, par_bit;

   assign wr        = iocs & ~iorw & (ioaddr == 2'b00);
   assign bit_end   = (state != IDLE) && brg_en && (sample_cnt == CNT_W'(SAMPLE_RATE-1));
   assign last_stop = (state == STOP) && bit_end && (stop_cnt == two_q);
   // A full holding register is drained either from IDLE on a tick or
   // directly at the end of the last stop bit, so back-to-back frames have no gap.
   assign load      = hold_full && (((state == IDLE) && brg_en) || last_stop);
   assign accept    = wr && (!hold_full || load);
   assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
   assign par_bit   = (par_q == 2'b01) ? ^payload : ~^payload;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         hold_reg   <= '0;
         hold_full  <= 1'b0;
         shifter    <= '0;
         payload    <= '0;
         par_q      <= 2'b00;
         two_q      <= 1'b0;
         tbr        <= 1'b1;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         txd        <= 1'b1;
      end else begin
         overrun <= wr & ~accept;

         if (accept) begin
            hold_reg  <= data_in;
            hold_full <= 1'b1;
            tbr       <= 1'b0;
         end else if (load) begin
            hold_full <= 1'b0;
            tbr       <= 1'b1;
         end

         if ((state != IDLE) && brg_en)
            sample_cnt <= bit_end ? '0 : sample_cnt + 1'b1;

         if (load) begin
            // Configuration is frozen here for the whole frame.
            shifter    <= hold_reg;
            payload    <= hold_reg;
            par_q      <= parity_mode;
            two_q      <= two_stop;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            txd        <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
         end else if (bit_end) begin
            case (state)
               START: begin
                  state   <= DATA;
                  txd     <= shifter[0];
                  bit_cnt <= '0;
               end
               DATA: begin
                  if (bit_cnt == 4'(DATA_BITS-1)) begin
                     if (par_en) begin
                        state <= PARITY;
                        txd   <= par_bit;
                     end else begin
                        state    <= STOP;
                        txd      <= 1'b1;
                        stop_cnt <= 1'b0;
                     end
                  end else begin
                     shifter <= shifter >> 1;
                     txd     <= shifter[1];
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               PARITY: begin
                  state    <= STOP;
                  txd      <= 1'b1;
                  stop_cnt <= 1'b0;
               end
               STOP: begin
                  if (last_stop) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     txd   <= 1'b1;
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spart_tx_engine.sv
// Scoreboard bench for spart_tx_engine: an 8-bit/16x build on a divided tick
// plus 5-bit and 9-bit 4x builds on a continuous tick.
module tb_spart_tx_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [1:0] ioaddr;
   logic       iorw;
   logic       iocs, iocs5, iocs9;
   logic [7:0] data_in;
   logic [4:0] d5;
   logic [8:0] d9;
   logic       brg_en, brg_hi;
   logic [1:0] pm, pm5, pm9;
   logic       ts, ts5, ts9;
   logic       tbr, busy, overrun, txd;
   logic       tbr5, busy5, ov5, txd5;
   logic       tbr9, busy9, ov9, txd9;

   assign brg_hi = 1'b1;

   spart_tx_engine #(.DATA_BITS(8), .SAMPLE_RATE(16)) dut (
      .clk(clk), .rst_n(rst_n), .ioaddr(ioaddr), .iorw(iorw), .iocs(iocs),
      .data_in(data_in), .brg_en(brg_en), .parity_mode(pm), .two_stop(ts),
      .tbr(tbr), .busy(busy), .overrun(overrun), .txd(txd));

   spart_tx_engine #(.DATA_BITS(5), .SAMPLE_RATE(4)) dut5 (
      .clk(clk), .rst_n(rst_n), .ioaddr(ioaddr), .iorw(iorw), .iocs(iocs5),
      .data_in(d5), .brg_en(brg_hi), .parity_mode(pm5), .two_stop(ts5),
      .tbr(tbr5), .busy(busy5), .overrun(ov5), .txd(txd5));

   spart_tx_engine #(.DATA_BITS(9), .SAMPLE_RATE(4)) dut9 (
      .clk(clk), .rst_n(rst_n), .ioaddr(ioaddr), .iorw(iorw), .iocs(iocs9),
      .data_in(d9), .brg_en(brg_hi), .parity_mode(pm9), .two_stop(ts9),
      .tbr(tbr9), .busy(busy9), .overrun(ov9), .txd(txd9));

   int bcnt = 0;
   always @(negedge clk) begin
      bcnt   = (bcnt + 1) % 4;
      brg_en = (bcnt == 0);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] bits;
      int          len;
   } frame_t;

   frame_t sb [3][$];
   int     start_q [3][$];
   bit     mon_en [3];
   int     tests = 0;
   int     fails = 0;

   function automatic frame_t make_frame(logic [8:0] d, int n, logic [1:0] p, bit two);
      frame_t f;
      int idx, ones;
      f.bits = '0;
      f.bits[0] = 1'b0;
      idx  = 1;
      ones = 0;
      for (int i = 0; i < n; i++) begin
         f.bits[idx] = d[i];
         idx++;
         if (d[i]) ones++;
      end
      if (p == 2'b01) begin f.bits[idx] = (ones % 2 == 1); idx++; end
      if (p == 2'b10) begin f.bits[idx] = (ones % 2 == 0); idx++; end
      f.bits[idx] = 1'b1; idx++;
      if (two) begin f.bits[idx] = 1'b1; idx++; end
      f.len = idx;
      return f;
   endfunction

   function automatic logic tx_of(int w);
      case (w)
         0:       return txd;
         1:       return txd5;
         default: return txd9;
      endcase
   endfunction

   function automatic logic busy_of(int w);
      case (w)
         0:       return busy;
         1:       return busy5;
         default: return busy9;
      endcase
   endfunction

   // Decodes each frame by sampling mid-bit and checks it against the oldest expected frame.
   task automatic monitor(int w, int bitclk);
      logic prev, cur;
      logic [15:0] got;
      frame_t e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         cur = tx_of(w);
         if (mon_en[w] && prev === 1'b1 && cur === 1'b0) begin
            start_q[w].push_back(cyc);
            if (sb[w].size() == 0) begin
               tests++; fails++;
               $display("FAIL mon%0d_unexpected_frame: start bit seen at cycle %0d, none expected", w, cyc);
            end else begin
               e = sb[w].pop_front();
               got = '0;
               repeat (bitclk/2) @(negedge clk);
               for (int k = 0; k < e.len; k++) begin
                  got[k] = tx_of(w);
                  if (k < e.len-1) repeat (bitclk) @(negedge clk);
               end
               tests++;
               if (got !== e.bits) begin
                  fails++;
                  $display("FAIL mon%0d_frame: got bits %b, expected %b (len %0d)", w, got, e.bits, e.len);
               end
               cur = tx_of(w);
            end
         end
         prev = cur;
      end
   endtask

   initial monitor(0, 64);
   initial monitor(1, 4);
   initial monitor(2, 4);

   task automatic wr_main(logic [7:0] d);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; data_in = d;
      @(negedge clk);
      iocs = 1'b0;
   endtask

   task automatic wait_rise(int w, int limit, output bit to);
      int n = 0;
      while (busy_of(w) !== 1'b1 && n < limit) begin @(negedge clk); n++; end
      to = (n >= limit);
   endtask

   task automatic busy_len(int w, int limit, output int len);
      len = 0;
      while (busy_of(w) === 1'b1 && len < limit) begin len++; @(negedge clk); end
   endtask

   task automatic drain(int w, int limit, output bit to);
      int n = 0;
      while ((sb[w].size() != 0 || busy_of(w) === 1'b1) && n < limit) begin @(negedge clk); n++; end
      to = (n >= limit);
   endtask

   task automatic test_reset();
      bit to;
      int bad;
      tests++; if (txd !== 1'b1)     begin fails++; $display("FAIL rst_txd: got %b, expected 1", txd); end
      tests++; if (tbr !== 1'b1)     begin fails++; $display("FAIL rst_tbr: got %b, expected 1", tbr); end
      tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL rst_busy: got %b, expected 0", busy); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %b, expected 0", overrun); end
      tests++; if (txd5 !== 1'b1 || txd9 !== 1'b1) begin fails++; $display("FAIL rst_txd_w: got %b/%b, expected 1/1", txd5, txd9); end

      mon_en[0] = 1'b0;
      pm = 2'b00; ts = 1'b0;
      wr_main(8'hA5);
      wait_rise(0, 20, to);
      tests++; if (to) begin fails++; $display("FAIL rst_frame_start: busy never rose, expected 1"); end
      repeat (64*3) @(negedge clk);
      wr_main(8'h3C);
      tests++; if (tbr !== 1'b0) begin fails++; $display("FAIL rst_hold_full: tbr got %b, expected 0", tbr); end
      #1 rst_n = 1'b0;
      #1;
      tests++; if (txd !== 1'b1 || tbr !== 1'b1 || busy !== 1'b0)
         begin fails++; $display("FAIL rst_async: txd/tbr/busy got %b%b%b, expected 110", txd, tbr, busy); end
      @(negedge clk) rst_n = 1'b1;
      bad = 0;
      repeat (800) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL rst_residual: %0d active cycles after reset, expected 0", bad); end
      tests++; if (tbr !== 1'b1) begin fails++; $display("FAIL rst_buffer_cleared: tbr got %b, expected 1", tbr); end
      mon_en[0] = 1'b1;
   endtask

   task automatic test_8n1();
      bit to;
      int len;
      pm = 2'b00; ts = 1'b0;
      // A read and a write to another address must not touch the buffer.
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; data_in = 8'hFF;
      @(negedge clk);
      iorw = 1'b0; ioaddr = 2'b01;
      @(negedge clk);
      iocs = 1'b0; ioaddr = 2'b00;
      tests++; if (tbr !== 1'b1) begin fails++; $display("FAIL decode_ignore: tbr got %b, expected 1", tbr); end

      sb[0].push_back(make_frame(9'h0A5, 8, 2'b00, 1'b0));
      wr_main(8'hA5);
      tests++; if (tbr !== 1'b0) begin fails++; $display("FAIL 8n1_tbr_low: got %b, expected 0", tbr); end
      wait_rise(0, 20, to);
      tests++; if (to) begin fails++; $display("FAIL 8n1_start: busy never rose, expected 1"); end
      busy_len(0, 2000, len);
      tests++; if (len != 640) begin fails++; $display("FAIL 8n1_frame_len: got %0d clk, expected 640", len); end
      drain(0, 2000, to);
      tests++; if (to || tbr !== 1'b1) begin fails++; $display("FAIL 8n1_drain: timeout %b tbr %b, expected 0 1", to, tbr); end
   endtask

   task automatic test_parity();
      logic [1:0] pms [3] = '{2'b01, 2'b10, 2'b00};
      bit         tss [3] = '{1'b0, 1'b1, 1'b1};
      int         exp_len [3] = '{704, 768, 704};
      bit to;
      int len;
      for (int c = 0; c < 3; c++) begin
         pm = pms[c]; ts = tss[c];
         sb[0].push_back(make_frame(9'h007, 8, pms[c], tss[c]));
         wr_main(8'h07);
         wait_rise(0, 20, to);
         // Mid-frame config changes must not affect the frame in flight.
         pm = ~pms[c]; ts = ~tss[c];
         busy_len(0, 2000, len);
         tests++; if (to || len != exp_len[c])
            begin fails++; $display("FAIL parity_len_%0d: got %0d clk, expected %0d", c, len, exp_len[c]); end
         drain(0, 2000, to);
         tests++; if (to) begin fails++; $display("FAIL parity_drain_%0d: timed out, expected idle", c); end
      end
      pm = 2'b00; ts = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit to;
      int n;
      pm = 2'b00; ts = 1'b0;
      start_q[0].delete();
      sb[0].push_back(make_frame(9'h055, 8, 2'b00, 1'b0));
      wr_main(8'h55);
      wait_rise(0, 20, to);
      repeat (64*3) @(negedge clk);
      tests++; if (tbr !== 1'b1) begin fails++; $display("FAIL b2b_tbr_free: got %b, expected 1", tbr); end
      sb[0].push_back(make_frame(9'h00F, 8, 2'b00, 1'b0));
      wr_main(8'h0F);
      tests++; if (tbr !== 1'b0) begin fails++; $display("FAIL b2b_tbr_held: got %b, expected 0", tbr); end
      n = 0;
      while (tbr !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      tests++; if (n >= 2000 || busy !== 1'b1)
         begin fails++; $display("FAIL b2b_reload: waited %0d, busy %b, expected busy 1", n, busy); end
      drain(0, 3000, to);
      tests++; if (to || start_q[0].size() != 2)
         begin fails++; $display("FAIL b2b_frames: timeout %b, %0d starts, expected 2", to, start_q[0].size()); end
      else begin
         tests++; if (start_q[0][1] - start_q[0][0] != 640)
            begin fails++; $display("FAIL b2b_gap: start spacing %0d, expected 640", start_q[0][1] - start_q[0][0]); end
      end
   endtask

   task automatic test_overrun();
      bit to;
      sb[0].push_back(make_frame(9'h011, 8, 2'b00, 1'b0));
      wr_main(8'h11);
      wait_rise(0, 20, to);
      repeat (64) @(negedge clk);
      sb[0].push_back(make_frame(9'h022, 8, 2'b00, 1'b0));
      wr_main(8'h22);
      tests++; if (overrun !== 1'b0 || tbr !== 1'b0)
         begin fails++; $display("FAIL ovr_accept: overrun %b tbr %b, expected 0 0", overrun, tbr); end
      wr_main(8'h33);
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_pulse: got %b, expected 1", overrun); end
      @(negedge clk);
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_one_cycle: got %b, expected 0", overrun); end
      tests++; if (tbr !== 1'b0) begin fails++; $display("FAIL ovr_hold_kept: tbr got %b, expected 0", tbr); end
      drain(0, 3000, to);
      tests++; if (to) begin fails++; $display("FAIL ovr_drain: timed out, expected idle"); end
   endtask

   task automatic test_width();
      bit to;
      int len;
      pm5 = 2'b10; ts5 = 1'b1;
      sb[1].push_back(make_frame(9'h01F, 5, 2'b10, 1'b1));
      @(negedge clk); iocs5 = 1'b1; iorw = 1'b0; ioaddr = 2'b00; d5 = 5'h1F;
      @(negedge clk); iocs5 = 1'b0;
      wait_rise(1, 10, to);
      busy_len(1, 200, len);
      tests++; if (to || len != 36) begin fails++; $display("FAIL w5_len: got %0d clk, expected 36", len); end
      drain(1, 200, to);
      tests++; if (to) begin fails++; $display("FAIL w5_drain: timed out, expected idle"); end

      // Second write lands in the load cycle: accepted; third one is dropped.
      pm9 = 2'b01; ts9 = 1'b0;
      start_q[2].delete();
      @(negedge clk); iocs9 = 1'b1; iorw = 1'b0; ioaddr = 2'b00; d9 = 9'h1FF;
      sb[2].push_back(make_frame(9'h1FF, 9, 2'b01, 1'b0));
      @(negedge clk);
      tests++; if (ov9 !== 1'b0) begin fails++; $display("FAIL w9_first_ovr: got %b, expected 0", ov9); end
      d9 = 9'h0AA;
      sb[2].push_back(make_frame(9'h0AA, 9, 2'b01, 1'b0));
      @(negedge clk);
      tests++; if (ov9 !== 1'b0 || tbr9 !== 1'b0)
         begin fails++; $display("FAIL w9_same_cycle: overrun %b tbr %b, expected 0 0", ov9, tbr9); end
      d9 = 9'h033;
      @(negedge clk); iocs9 = 1'b0;
      tests++; if (ov9 !== 1'b1) begin fails++; $display("FAIL w9_overrun: got %b, expected 1", ov9); end
      @(negedge clk);
      tests++; if (ov9 !== 1'b0) begin fails++; $display("FAIL w9_overrun_clear: got %b, expected 0", ov9); end
      drain(2, 500, to);
      tests++; if (to || start_q[2].size() != 2 || tbr9 !== 1'b1)
         begin fails++; $display("FAIL w9_frames: timeout %b, %0d starts, tbr %b, expected 0 2 1", to, start_q[2].size(), tbr9); end
      else begin
         tests++; if (start_q[2][1] - start_q[2][0] != 48)
            begin fails++; $display("FAIL w9_gap: start spacing %0d, expected 48", start_q[2][1] - start_q[2][0]); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      iocs = 1'b0; iocs5 = 1'b0; iocs9 = 1'b0;
      iorw = 1'b1; ioaddr = 2'b00;
      data_in = '0; d5 = '0; d9 = '0;
      pm = 2'b00; pm5 = 2'b00; pm9 = 2'b00;
      ts = 1'b0; ts5 = 1'b0; ts9 = 1'b0;
      mon_en[0] = 1'b0; mon_en[1] = 1'b1; mon_en[2] = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_overrun();
      test_width();

      repeat (10) @(negedge clk);
      for (int w = 0; w < 3; w++) begin
         tests++;
         if (sb[w].size() != 0) begin
            fails++;
            $display("FAIL sb%0d_empty: %0d frames outstanding, expected 0", w, sb[w].size());
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
